alu_ctrl_seq: RTL
=================

// Module: alu_ctrl_seq
// PURPOSE
//  Upstream control stage for the 8-bit ALU. Accepts decoded instructions over a valid/ready
//  handshake and reads operands from a small register file. Drives the ALU operand/op_code/
//  ALU_ce/carry_ce inputs, then captures o_main/carry_out and writes the result back.
//  Holds the architectural carry and zero flags. Three-cycle, non-pipelined sequencer.
// PARAMETERS
//  NUM_REGS   4   register-file depth (power of 2, >=2)
//  DATA_W     8   datapath width; must match ALU (8)
//  RA_W       2   register address width = $clog2(NUM_REGS)
// PORTS
//  clk              in   1       single clock, all state on rising edge
//  rst_n            in   1       synchronous, active-low reset
//  instr_valid      in   1       instruction present
//  instr_ready      out  1       sequencer can accept (high only in IDLE)
//  instr_op         in   3       instruction_code (alu_pkg)
//  instr_rd         in   RA_W    destination / first operand register
//  instr_rs         in   RA_W    second operand register
//  instr_imm_en     in   1       1: second operand = instr_imm, 0: reg[instr_rs]
//  instr_imm        in   DATA_W  immediate operand
//  instr_use_carry  in   1       ADD only: feed carry flag into ALU carry_ce
//  alu_i_1          out  DATA_W  to ALU i_1
//  alu_i_2          out  DATA_W  to ALU i_2
//  alu_op_code      out  3       to ALU op_code
//  alu_ce           out  1       to ALU ALU_ce
//  alu_carry_ce     out  1       to ALU carry_ce
//  alu_result       in   DATA_W  from ALU o_main
//  alu_carry_out    in   1       from ALU carry_out
//  done             out  1       1-cycle pulse on writeback (or illegal retire)
//  illegal          out  1       1-cycle pulse, coincident with done, for op 3'b111
//  flag_c           out  1       carry flag
//  flag_z           out  1       zero flag
//  dbg_addr         in   RA_W    debug register read address
//  dbg_data         out  DATA_W  reg[dbg_addr], combinational read of stored value
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state<=IDLE; all regs, flag_c, flag_z, alu_i_1/2, alu_op_code <= 0.
//   alu_ce, alu_carry_ce, done, illegal <= 0. Reset mid-instruction abandons it with no writeback.
//  FSM IDLE -> EXEC -> WB -> IDLE. No stalls; WB is never skipped.
//  IDLE: instr_ready=1. On valid&ready, register operands:
//   alu_i_1 <= reg[rd]
//   alu_i_2 <= imm_en ? imm : reg[rs]
//   alu_op_code <= op; rd latched
//   alu_carry_ce <= use_carry & (op==ADD) & flag_c
//   go to EXEC.
//  EXEC: alu_ce=1 (registered, high for exactly this cycle); instr_ready=0.
//   Capture res<=alu_result and c<=alu_carry_out at end of cycle. Go to WB.
//  WB: done=1.
//   If op!=3'b111: reg[rd]<=res; flag_z<=(res==0).
//   If op==ADD: flag_c<=c. Other ops leave flag_c unchanged.
//   If op==3'b111: illegal=1; no reg/flag update.
//   Return to IDLE.
//  Latency: accept at edge T, alu_ce high T..T+1, done high T+1..T+2,
//   reg visible from T+2 (dbg_data). Throughput: 1 instr / 3 cycles.
//  Outside EXEC, alu_i_1/alu_i_2/alu_op_code hold their last value (ALU holds o_main when ALU_ce=0).
//  NOT_OP uses alu_i_1 only. LOAD writes alu_i_2 to rd.
//  Arithmetic is mod 2^DATA_W; the ALU handles wrap. The sequencer never widens.
//  rd==rs reads the same value into both operands.
//  dbg_data during the WB cycle shows the old value; new value appears the cycle after.
//  instr_valid while not ready: ignored. The sender must hold the fields until accepted.
// STRUCTURE
//  alu_pkg: add typedef enum logic[1:0] {S_IDLE,S_EXEC,S_WB} seq_state_t; OP_ILLEGAL=3'b111.
//   Reuse instruction_code for instr_op/alu_op_code.
//  Sub-module alu_regfile: NUM_REGS x DATA_W, 1 sync write, 3 comb reads (rd, rs, dbg), sync reset.
// TESTING
//  1. Reset: hold rst_n=0 2 clks -> all regs 0, flag_c=0, flag_z=0, instr_ready=1, done=0.
//  2. LOAD imm 0xF0->r0, then LOAD 0x20->r1, then ADD r0,r1 -> r0=0x10, flag_c=1, flag_z=0.
//     done exactly 2 cycles after each accept.
//  3. With flag_c=1: ADD use_carry imm 0x00 to r0=0x10 -> alu_carry_ce=1, r0=0x11, flag_c=0.
//  4. SUBTRACT r1=0x20 minus imm 0x20 -> r1=0x00, flag_z=1, flag_c unchanged.
//     XOR r2,r2 -> 0x00, flag_z=1.
//  5. op=3'b111 with rd=r0 -> illegal and done pulse together, r0 and flags unchanged.
//  6. Assert rst_n=0 during EXEC of ADD to r3 -> no writeback, r3=0, state IDLE next cycle.
//     Also hold instr_valid=1 back-to-back -> accepts only every 3rd cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU control sequencer: instruction codes and FSM states.
// OP_ILLEGAL names the reserved code that retires without touching state.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD      = 3'b000,
    SUBTRACT = 3'b001,
    AND_OP   = 3'b010,
    OR_OP    = 3'b011,
    XOR_OP   = 3'b100,
    NOT_OP   = 3'b101,
    LOAD     = 3'b110,
    RESERVED = 3'b111
  } instruction_code;

  localparam instruction_code OP_ILLEGAL = RESERVED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, three combinational reads
// (first operand, second operand, debug), cleared by synchronous reset.
module alu_regfile #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RA_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RA_W-1:0]   raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [RA_W-1:0]   raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [RA_W-1:0]   raddr_dbg_i,
  output logic [DATA_W-1:0] rdata_dbg_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = mem_q[raddr_a_i];
  assign rdata_b_o   = mem_q[raddr_b_i];
  assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule

// File: rtl/alu_ctrl_seq.sv
// Three-cycle non-pipelined sequencer in front of the 8-bit ALU: IDLE accepts and
// registers operands, EXEC strobes the ALU, WB writes the result and flags back.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_rs,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_carry,
  output logic [DATA_W-1:0] alu_i_1,
  output logic [DATA_W-1:0] alu_i_2,
  output logic [2:0]        alu_op_code,
  output logic              alu_ce,
  output logic              alu_carry_ce,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  output logic              done,
  output logic              illegal,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  seq_state_t        state_q;
  instruction_code   op_q;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] i1_q, i2_q, res_q;
  logic              c_q, ce_q, cce_q, done_q, ill_q, fc_q, fz_q;
  logic [DATA_W-1:0] rd_data, rs_data;
  logic              we;

  assign we = (state_q == S_WB) && (op_q != OP_ILLEGAL);

  alu_regfile #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .RA_W    (RA_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we),
    .waddr_i    (rd_q),
    .wdata_i    (res_q),
    .raddr_a_i  (instr_rd),
    .rdata_a_o  (rd_data),
    .raddr_b_i  (instr_rs),
    .rdata_b_o  (rs_data),
    .raddr_dbg_i(dbg_addr),
    .rdata_dbg_o(dbg_data)
  );

  // Strobes default low every cycle so each is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= ADD;
      rd_q    <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      ce_q    <= 1'b0;
      cce_q   <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      ce_q   <= 1'b0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            i1_q    <= rd_data;
            i2_q    <= instr_imm_en ? instr_imm : rs_data;
            op_q    <= instruction_code'(instr_op);
            rd_q    <= instr_rd;
            cce_q   <= instr_use_carry && (instr_op == ADD) && fc_q;
            ce_q    <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= alu_result;
          c_q     <= alu_carry_out;
          cce_q   <= 1'b0;
          done_q  <= 1'b1;
          ill_q   <= (op_q == OP_ILLEGAL);
          state_q <= S_WB;
        end
        S_WB: begin
          if (op_q != OP_ILLEGAL) fz_q <= (res_q == '0);
          if (op_q == ADD) fc_q <= c_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign alu_i_1      = i1_q;
  assign alu_i_2      = i2_q;
  assign alu_op_code  = op_q;
  assign alu_ce       = ce_q;
  assign alu_carry_ce = cce_q;
  assign done         = done_q;
  assign illegal      = ill_q;
  assign flag_c       = fc_q;
  assign flag_z       = fz_q;

endmodule
